// File: rtl/intt_twiddle_gen.sv
// intt_twiddle_gen
//   Per-stage INTT twiddle sequencer. On an accepted stage start it presents the
//   stage half-span to the twiddle-base ROM, captures the registered base g1, and
//   then streams w_j = g1^j mod Q (j = 0 .. mid-1) over a valid/ready handshake.
//
//   Optional build macro: INTT_TWID_PREFETCH_EN
//     Enables a shadow multiply pipeline in EMIT that precomputes the next
//     twiddle. This hides the multiply bubble when the consumer is slower than
//     the pipeline. The emitted sequence is identical to the default build.
//
// Ports
//   clk, rst  : clock, asynchronous active-high reset
//   start     : stage-start pulse, sampled only in IDLE
//   mid_in    : stage half-span (legal: 1,2,4,...,128)
//   rom_mid   : address to the twiddle-base ROM (held until next accepted start)
//   rom_g1    : registered ROM data (valid one cycle after rom_mid changes)
//   busy      : stage in progress
//   tw_valid  : twiddle available        tw_ready : consumer accepts twiddle
//   tw_data   : current twiddle w_j      tw_idx   : j of current twiddle
//   tw_last   : tw_valid and j == mid-1
//   done      : one-cycle pulse after the last twiddle is accepted
//   err       : one-cycle pulse when start carries an illegal mid
module intt_twiddle_gen #(
  parameter int unsigned Q  = 8380417,
  parameter int unsigned DW = 24,
  parameter int unsigned MW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [MW-1:0] mid_in,
  output logic [MW-1:0] rom_mid,
  input  logic [DW-1:0] rom_g1,
  output logic          busy,
  output logic          tw_valid,
  input  logic          tw_ready,
  output logic [DW-1:0] tw_data,
  output logic [7:0]    tw_idx,
  output logic          tw_last,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {IDLE, ROM_WAIT, LOAD, EMIT, MUL1, MUL2, FIN} state_t;

  state_t          state, state_nxt;
  logic [MW-1:0]   mid_reg;
  logic [DW-1:0]   g1_reg;
  logic [2*DW-1:0] prod;
  logic [2*DW-1:0] mult;
  logic            legal;
  logic            is_last;
  logic            present;

`ifdef INTT_TWID_PREFETCH_EN
  logic            pres;    // tw_data holds a fresh, not yet accepted twiddle
  logic            mul_go;  // tw_data changed; multiply it by g1 next cycle
  logic            pv;      // prod holds tw_data * g1
  logic            nv;      // nxt holds the reduced next twiddle
  logic [DW-1:0]   nxt;
  assign present = pres;
`else
  assign present = 1'b1;
`endif

  // Reduction is specialised to Q = 2^23 - 2^13 + 1, using 2^23 == 2^13 - 1.
  // Three folds bring any 48-bit product below 2*Q; one subtract finishes.
  function automatic logic [DW-1:0] mod_q(input logic [2*DW-1:0] x);
    logic [38:0] y;
    logic [28:0] z;
    logic [24:0] w;
    y = 39'(x[2*DW-1:23]) * 39'd8191 + 39'(x[22:0]);
    z = 29'(y[38:23]) * 29'd8191 + 29'(y[22:0]);
    w = 25'(z[28:23]) * 25'd8191 + 25'(z[22:0]);
    if (w >= 25'(Q)) w = w - 25'(Q);
    return w[DW-1:0];
  endfunction

  assign mult     = (2*DW)'(tw_data) * (2*DW)'(g1_reg);
  assign legal    = (mid_in != '0) && ((mid_in & (mid_in - MW'(1))) == '0) &&
                    (mid_in <= MW'(128));
  assign is_last  = (MW'(tw_idx) == (mid_reg - MW'(1)));
  assign tw_valid = (state == EMIT) && present;
  assign tw_last  = tw_valid && is_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:     if (start && legal) state_nxt = ROM_WAIT;
      ROM_WAIT: begin busy = 1'b1; state_nxt = LOAD; end
      LOAD:     begin busy = 1'b1; state_nxt = EMIT; end
      EMIT: begin
        busy = 1'b1;
        if (tw_valid && tw_ready) begin
`ifdef INTT_TWID_PREFETCH_EN
          if (is_last) state_nxt = FIN;
`else
          state_nxt = is_last ? FIN : MUL1;
`endif
        end
      end
      MUL1:     begin busy = 1'b1; state_nxt = MUL2; end
      MUL2:     begin busy = 1'b1; state_nxt = EMIT; end
      FIN:      begin done = 1'b1; state_nxt = IDLE; end
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err     <= 1'b0;
      rom_mid <= '0;
      mid_reg <= '0;
      g1_reg  <= '0;
      prod    <= '0;
      tw_data <= '0;
      tw_idx  <= '0;
`ifdef INTT_TWID_PREFETCH_EN
      pres    <= 1'b0;
      mul_go  <= 1'b0;
      pv      <= 1'b0;
      nv      <= 1'b0;
      nxt     <= '0;
`endif
    end else begin
      err <= (state == IDLE) && start && !legal;
      if ((state == IDLE) && start && legal) begin
        mid_reg <= mid_in;
        rom_mid <= mid_in;
      end
      case (state)
        LOAD: begin
          g1_reg  <= rom_g1;
          tw_data <= DW'(1);
          tw_idx  <= '0;
`ifdef INTT_TWID_PREFETCH_EN
          pres    <= 1'b1;
          mul_go  <= 1'b1;
          pv      <= 1'b0;
          nv      <= 1'b0;
`endif
        end
`ifdef INTT_TWID_PREFETCH_EN
        // A single token walks mul_go -> pv -> nv. The presentation logic below
        // is written last so its token updates take priority on the same edge.
        EMIT: begin
          if (mul_go) begin
            prod   <= mult;
            pv     <= 1'b1;
            mul_go <= 1'b0;
          end
          if (pv) begin
            nxt <= mod_q(prod);
            nv  <= 1'b1;
            pv  <= 1'b0;
          end
          if (pres) begin
            if (tw_ready && !is_last) begin
              if (nv) begin
                tw_data <= nxt;
                tw_idx  <= tw_idx + 8'd1;
                nv      <= 1'b0;
                mul_go  <= 1'b1;
              end else begin
                pres <= 1'b0;
              end
            end
          end else if (nv) begin
            tw_data <= nxt;
            tw_idx  <= tw_idx + 8'd1;
            nv      <= 1'b0;
            pres    <= 1'b1;
            mul_go  <= 1'b1;
          end else if (pv) begin
            // Bypass the nxt register when the consumer is already waiting.
            tw_data <= mod_q(prod);
            tw_idx  <= tw_idx + 8'd1;
            pv      <= 1'b0;
            nv      <= 1'b0;
            pres    <= 1'b1;
            mul_go  <= 1'b1;
          end
        end
`else
        MUL1: prod <= mult;
        MUL2: begin
          tw_data <= mod_q(prod);
          tw_idx  <= tw_idx + 8'd1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
